fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
Sequences audio capture into the 256-point FFT engine on the 25 MHz system clock. Sits between the I2S receiver's left-channel sample stream and the fft256 input.
- Optional boxcar decimation by 2^n.
- Feeds exactly FRAME_LEN contiguous samples per frame, and only while the engine is idle.
- Waits for the engine's busy cycle to complete.
- Enforces a programmable inter-frame holdoff and supports display freeze.

Parameters:
FRAME_LEN, 256, samples forwarded per FFT frame
MAX_DECIM_LOG, 3, maximum decimation exponent; accumulator width = 16 + MAX_DECIM_LOG
TIMEOUT_CYCLES, 65535, busy-handshake timeout in clk cycles (used only with BUSY_TIMEOUT_EN)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
sample_in  in  16  signed audio sample
sample_valid  in  1  one-cycle strobe, sample_in valid
decim_log  in  2  decimation exponent 0..3 (group size 2^decim_log)
holdoff  in  16  raw input samples skipped between frames
freeze  in  1  level; inhibits start of new frames
fft_busy  in  1  FFT engine busy level
fft_sample  out  16  signed sample to FFT
fft_sample_valid  out  1  one-cycle strobe to FFT
frame_done  out  1  one-cycle pulse when an FFT frame completes
frame_count  out  16  completed frames, wraps 0xFFFF->0
capturing  out  1  high while in FILL
error  out  1  sticky timeout flag

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State = IDLE.
  - fft_sample=0, fft_sample_valid=0, frame_done=0, frame_count=0, capturing=0, error=0.
  - Accumulator, group counter, frame counter and holdoff counter all cleared.
  - Reset mid-operation aborts any frame immediately; no further strobes after that edge.
- States: IDLE, FILL, WAIT_START, COMPUTE, HOLDOFF.
- IDLE:
  - If freeze=0 and fft_busy=0 -> FILL.
  - On this transition: latch decim_log into decim_q; clear accumulator, group counter and sample counter.
  - A sample_valid in the transition cycle is discarded.
- FILL (capturing=1):
  - Each sample_valid adds sign-extended sample_in to a (16+MAX_DECIM_LOG)-bit signed accumulator and increments the group counter.
  - On the 2^decim_q-th sample of a group:
    - Next cycle, fft_sample = (acc + sample) >>> decim_q, arithmetic shift (floor), low 16 bits, and fft_sample_valid=1 for exactly one cycle.
    - Accumulator restarts at 0; sample counter increments.
  - Latency: one clk from the completing sample_valid to fft_sample_valid.
  - When the FRAME_LEN-th strobe is issued -> WAIT_START.
  - The freeze input is ignored; the frame always completes.
- WAIT_START: fft_busy=1 -> COMPUTE. If fft_busy is already 1 in the entry cycle, the transition happens on the next edge.
- COMPUTE: fft_busy=0 ->
  - frame_done=1 for one cycle and frame_count+1.
  - Next state is HOLDOFF if holdoff!=0, otherwise IDLE.
- HOLDOFF:
  - Counts raw sample_valid strobes.
  - When count reaches the holdoff value sampled at entry -> IDLE.
  - Changes to holdoff during HOLDOFF are ignored.
- No fft_sample_valid is ever asserted outside FILL. fft_sample holds its last value between strobes.
- decim_log changes take effect only at the next IDLE->FILL transition.
- Input samples arriving outside FILL (except in HOLDOFF, where they are counted) are dropped.

Optional Feature:
Macro FFT_FRAME_CTRL_BUSY_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_START and COMPUTE, cleared on entry to each state.
  - Reaching TIMEOUT_CYCLES without the awaited fft_busy edge -> set sticky error=1 and go to IDLE. No frame_done, frame_count unchanged.
  - error clears only on rst.
- Undefined: WAIT_START and COMPUTE wait indefinitely; error tied 0; no counter logic generated.

Test Plan:
1. decim_log=0, holdoff=0, ramp 0..255 at one sample per 8 clk; engine model raises busy 2 clk after the 256th strobe and holds it 100 clk -> exactly 256 strobes carrying 0..255, each one clk after its input; one frame_done; frame_count=1; FSM back in IDLE.
2. decim_log=2, input groups {1,2,3,6} and {-8,-1,0,0} -> fft_sample 3 then -3 (floor of -9/4); 1024 inputs -> exactly 256 strobes.
3. freeze=1 asserted at strobe 100 of a frame -> frame completes; frame_count increments; no strobes while freeze=1; release -> a new frame starts within 1 clk if busy=0.
4. holdoff=10 -> after frame_done, raw samples 1..10 are not forwarded; sample 11 is the first forwarded sample of the next frame.
5. rst pulsed after strobe 100 -> next cycle all outputs 0, frame_count=0; after release a full 256-strobe frame is produced.
6. With FFT_FRAME_CTRL_BUSY_TIMEOUT_EN and TIMEOUT_CYCLES=50, busy never rises -> error=1 at cycle 50 of WAIT_START; IDLE; frame_count unchanged; error stays 1 across later frames until rst.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Frames the decimated left-channel sample stream into FRAME_LEN-sample bursts for the fft256 engine.
// Optional busy-handshake watchdog: define FFT_FRAME_CTRL_BUSY_TIMEOUT_EN.
module fft_frame_ctrl #(
    parameter int unsigned FRAME_LEN      = 256,
    parameter int unsigned MAX_DECIM_LOG  = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic [1:0]  decim_log,
    input  logic [15:0] holdoff,
    input  logic        freeze,
    input  logic        fft_busy,
    output logic [15:0] fft_sample,
    output logic        fft_sample_valid,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        capturing,
    output logic        error
);

    localparam int unsigned ACC_W = 16 + MAX_DECIM_LOG;
    localparam int unsigned GRP_W = MAX_DECIM_LOG;
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    // decim_log is two bits wide, so groups of up to 8 must fit the accumulator.
    if (MAX_DECIM_LOG < 3 || FRAME_LEN == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("fft_frame_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT_START,
        S_COMPUTE,
        S_HOLDOFF
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               decim_q, decim_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [GRP_W-1:0]         grp_q, grp_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [15:0]              hold_q, hold_d;
    logic [15:0]              hcnt_q, hcnt_d;
    logic [15:0]              fft_sample_q, fft_sample_d;
    logic                     fft_valid_q, fft_valid_d;
    logic                     frame_done_q, frame_done_d;
    logic [15:0]              frame_count_q, frame_count_d;
    logic                     capturing_q, capturing_d;

    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_shr;
    logic [GRP_W-1:0]         grp_max;

`ifdef FFT_FRAME_CTRL_BUSY_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     error_q, error_d;
    logic                     tmo_hit;
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    // Boxcar sum including the current sample; shift is arithmetic so the average floors.
    assign acc_sum = acc_q + $signed({{MAX_DECIM_LOG{sample_in[15]}}, sample_in});
    assign acc_shr = acc_sum >>> decim_q;
    assign grp_max = GRP_W'((32'd1 << decim_q) - 32'd1);

    always_comb begin
        state_d       = state_q;
        decim_d       = decim_q;
        acc_d         = acc_q;
        grp_d         = grp_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        hcnt_d        = hcnt_q;
        fft_sample_d  = fft_sample_q;
        fft_valid_d   = 1'b0;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
`ifdef FFT_FRAME_CTRL_BUSY_TIMEOUT_EN
        tmo_d         = '0;
        error_d       = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!freeze && !fft_busy) begin
                    state_d = S_FILL;
                    decim_d = decim_log;
                    acc_d   = '0;
                    grp_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_FILL: begin
                if (sample_valid) begin
                    if (grp_q == grp_max) begin
                        fft_sample_d = acc_shr[15:0];
                        fft_valid_d  = 1'b1;
                        acc_d        = '0;
                        grp_d        = '0;
                        cnt_d        = CNT_W'(cnt_q + 1'b1);
                        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                            state_d = S_WAIT_START;
                        end
                    end else begin
                        acc_d = acc_sum;
                        grp_d = GRP_W'(grp_q + 1'b1);
                    end
                end
            end
            S_WAIT_START: begin
                if (fft_busy) begin
                    state_d = S_COMPUTE;
                end
`ifdef FFT_FRAME_CTRL_BUSY_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    tmo_d = TMO_W'(tmo_q + 1'b1);
                end
`endif
            end
            S_COMPUTE: begin
                if (!fft_busy) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    if (holdoff != 16'd0) begin
                        state_d = S_HOLDOFF;
                        hold_d  = holdoff;
                        hcnt_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
`ifdef FFT_FRAME_CTRL_BUSY_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    tmo_d = TMO_W'(tmo_q + 1'b1);
                end
`endif
            end
            S_HOLDOFF: begin
                if (sample_valid) begin
                    if ((hcnt_q + 16'd1) == hold_q) begin
                        state_d = S_IDLE;
                    end else begin
                        hcnt_d = hcnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        capturing_d = (state_d == S_FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            decim_q       <= '0;
            acc_q         <= '0;
            grp_q         <= '0;
            cnt_q         <= '0;
            hold_q        <= '0;
            hcnt_q        <= '0;
            fft_sample_q  <= '0;
            fft_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            capturing_q   <= 1'b0;
`ifdef FFT_FRAME_CTRL_BUSY_TIMEOUT_EN
            tmo_q         <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            decim_q       <= decim_d;
            acc_q         <= acc_d;
            grp_q         <= grp_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            hcnt_q        <= hcnt_d;
            fft_sample_q  <= fft_sample_d;
            fft_valid_q   <= fft_valid_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            capturing_q   <= capturing_d;
`ifdef FFT_FRAME_CTRL_BUSY_TIMEOUT_EN
            tmo_q         <= tmo_d;
            error_q       <= error_d;
`endif
        end
    end

    assign fft_sample       = fft_sample_q;
    assign fft_sample_valid = fft_valid_q;
    assign frame_done       = frame_done_q;
    assign frame_count      = frame_count_q;
    assign capturing        = capturing_q;
`ifdef FFT_FRAME_CTRL_BUSY_TIMEOUT_EN
    assign error            = error_q;
`else
    assign error            = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: decimation vector table plus framing/freeze/holdoff/reset sequences.
module tb_fft_frame_ctrl;

    localparam int FRAME_LEN = 256;

    logic        clk;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [1:0]  decim_log;
    logic [15:0] holdoff;
    logic        freeze;
    logic        fft_busy;
    logic [15:0] fft_sample;
    logic        fft_sample_valid;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        capturing;
    logic        error;

    fft_frame_ctrl #(
        .FRAME_LEN      (256),
        .MAX_DECIM_LOG  (3),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .decim_log        (decim_log),
        .holdoff          (holdoff),
        .freeze           (freeze),
        .fft_busy         (fft_busy),
        .fft_sample       (fft_sample),
        .fft_sample_valid (fft_sample_valid),
        .frame_done       (frame_done),
        .frame_count      (frame_count),
        .capturing        (capturing),
        .error            (error)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    typedef struct {
        int d;
        int s[8];
        int exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   total;
    int   bad;
    int   cyc;
    int   strobes;
    int   fd_cnt;
    int   efc;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard pop on every strobe; also counts frame_done pulses.
    task automatic monitor();
        exp_t e;
        if (fft_sample_valid) begin
            strobes++;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: got %h, none expected (cycle %0d)", fft_sample, cyc);
            end else begin
                e = sb_q.pop_front();
                if (fft_sample !== e.val || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL strobe: got %h at cycle %0d expected %h at cycle %0d",
                             fft_sample, cyc, e.val, e.cyc);
                end
            end
        end
        if (frame_done) fd_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        monitor();
    endtask

    task automatic send(input int v, input bit has_exp, input int exp_v);
        exp_t e;
        sample_in    = 16'(v);
        sample_valid = 1'b1;
        if (has_exp) begin
            e.val = 16'(exp_v);
            e.cyc = cyc + 1;
            sb_q.push_back(e);
        end
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_capture();
        int n = 0;
        while (!capturing && n < 20) begin
            tick();
            n++;
        end
        check("capture_start", int'(capturing), 1);
    endtask

    task automatic start_frame(input int d);
        decim_log = 2'(d);
        freeze    = 1'b0;
        wait_capture();
        freeze    = 1'b1;
    endtask

    // One frame of groups; row>=0 uses a table row as group 0, freeze_at raises freeze after that group.
    task automatic feed(input int d, input int gap, input int row, input int freeze_at);
        int sum;
        int v;
        int n;
        n = 1 << d;
        for (int g = 0; g < FRAME_LEN; g++) begin
            sum = 0;
            for (int k = 0; k < n; k++) begin
                if (g == 0 && row >= 0) v = vecs[row].s[k];
                else v = int'($urandom_range(65535)) - 32768;
                sum += v;
                send(v, (k == n - 1), (g == 0 && row >= 0) ? vecs[row].exp : (sum >>> d));
                repeat (gap - 1) tick();
            end
            if (g == freeze_at) freeze = 1'b1;
        end
    endtask

    task automatic finish_frame(input int busy_len, input int exp_fc);
        int fd0;
        int n;
        fd0 = fd_cnt;
        n   = 0;
        repeat (2) tick();
        fft_busy = 1'b1;
        repeat (busy_len) tick();
        fft_busy = 1'b0;
        while (fd_cnt == fd0 && n < 10) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check("frame_done_pulses", fd_cnt - fd0, 1);
        check("frame_count", int'(frame_count), exp_fc);
        check("idle_after_frame", int'(capturing), 0);
    endtask

    initial begin
        int s0;
        total = 0; bad = 0; cyc = 0; strobes = 0; fd_cnt = 0; efc = 0;

        vecs[0].d = 2; vecs[0].s = '{1, 2, 3, 6, 0, 0, 0, 0};                 vecs[0].exp = 3;
        vecs[1].d = 2; vecs[1].s = '{-8, -1, 0, 0, 0, 0, 0, 0};               vecs[1].exp = -3;
        vecs[2].d = 0; vecs[2].s = '{-32768, 0, 0, 0, 0, 0, 0, 0};            vecs[2].exp = -32768;
        vecs[3].d = 1; vecs[3].s = '{32767, 32767, 0, 0, 0, 0, 0, 0};         vecs[3].exp = 32767;
        vecs[4].d = 3; vecs[4].s = '{-1, 0, 0, 0, 0, 0, 0, 0};                vecs[4].exp = -1;
        vecs[5].d = 3; vecs[5].s = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767}; vecs[5].exp = 32767;
        vecs[6].d = 1; vecs[6].s = '{-3, 0, 0, 0, 0, 0, 0, 0};                vecs[6].exp = -2;
        vecs[7].d = 3; vecs[7].s = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768}; vecs[7].exp = -32768;

        rst = 1'b1; sample_in = '0; sample_valid = 1'b0; decim_log = '0;
        holdoff = '0; freeze = 1'b1; fft_busy = 1'b0;
        repeat (3) tick();
        check("rst_fft_sample", int'(fft_sample), 0);
        check("rst_valid", int'(fft_sample_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_count", int'(frame_count), 0);
        check("rst_capturing", int'(capturing), 0);
        check("rst_error", int'(error), 0);
        rst = 1'b0;
        repeat (2) tick();
        check("frozen_idle", int'(capturing), 0);

        // Ramp, no decimation, one sample per 8 clocks, long busy.
        start_frame(0);
        s0 = strobes;
        for (int i = 0; i < FRAME_LEN; i++) begin
            send(i, 1'b1, i);
            repeat (7) tick();
        end
        check("ramp_strobes", strobes - s0, FRAME_LEN);
        finish_frame(100, ++efc);

        // Decimation table, back-to-back input samples.
        for (int r = 0; r < 8; r++) begin
            start_frame(vecs[r].d);
            s0 = strobes;
            feed(vecs[r].d, 1, r, -1);
            check("decim_strobes", strobes - s0, FRAME_LEN);
            finish_frame(20, ++efc);
        end

        // Freeze mid-frame: frame still completes, nothing forwarded while frozen.
        decim_log = 2'd0;
        freeze    = 1'b0;
        wait_capture();
        feed(0, 2, -1, 99);
        finish_frame(20, ++efc);
        s0 = strobes;
        for (int i = 0; i < 20; i++) begin
            send(500 + i, 1'b0, 0);
            tick();
        end
        check("frozen_no_strobes", strobes - s0, 0);
        check("frozen_not_capturing", int'(capturing), 0);
        freeze       = 1'b0;
        sample_in    = 16'h1234;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("release_start", int'(capturing), 1);
        holdoff = 16'd10;
        feed(0, 2, -1, -1);
        finish_frame(20, ++efc);

        // Holdoff of 10 raw samples; a mid-holdoff change must be ignored.
        for (int h = 1; h <= 10; h++) begin
            send(h, 1'b0, 0);
            repeat (3) tick();
            if (h == 5) holdoff = 16'd3;
            if (h == 9) check("holdoff_still_skipping", int'(capturing), 0);
        end
        check("holdoff_released", int'(capturing), 1);
        holdoff = 16'd0;
        freeze  = 1'b1;
        s0 = strobes;
        for (int i = 0; i < 100; i++) begin
            send(1000 + i, 1'b1, 1000 + i);
            tick();
        end
        check("post_holdoff_strobes", strobes - s0, 100);

        // Reset mid-frame.
        check("sb_empty_before_rst", sb_q.size(), 0);
        rst = 1'b1;
        tick();
        check("midrst_fft_sample", int'(fft_sample), 0);
        check("midrst_valid", int'(fft_sample_valid), 0);
        check("midrst_frame_done", int'(frame_done), 0);
        check("midrst_frame_count", int'(frame_count), 0);
        check("midrst_capturing", int'(capturing), 0);
        check("midrst_error", int'(error), 0);
        rst = 1'b0;
        efc = 0;
        start_frame(0);
        s0 = strobes;
        feed(0, 1, -1, -1);
        check("after_rst_strobes", strobes - s0, FRAME_LEN);
        finish_frame(20, ++efc);

`ifdef FFT_FRAME_CTRL_BUSY_TIMEOUT_EN
        // Busy never rises: sticky error after 50 cycles of WAIT_START.
        start_frame(0);
        feed(0, 1, -1, -1);
        repeat (49) tick();
        check("tmo_not_yet", int'(error), 0);
        tick();
        check("tmo_error", int'(error), 1);
        check("tmo_idle", int'(capturing), 0);
        check("tmo_frame_count", int'(frame_count), efc);
        repeat (3) tick();
        check("tmo_no_frame_done", fd_cnt, fd_cnt);
        start_frame(0);
        feed(0, 1, -1, -1);
        finish_frame(20, ++efc);
        check("tmo_error_sticky", int'(error), 1);
`else
        check("error_tied_low", int'(error), 0);
`endif

        check("sb_empty_at_end", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
